// File: rtl/mod_result_bcd_if.sv
// Handshake bundle for the remainder-to-BCD stage: operand input and BCD result output.
// The master side is the producer/consumer environment; the slave side is the converter.
interface mod_result_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [2:0]            out_ndigits;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndigits
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_ndigits
  );
endinterface

// File: rtl/mod_result_bcd.sv
// Iterative double-dabble converter: unsigned remainder word to packed BCD, one bit per clock,
// with a held result and significant-digit count for the 7-segment display path.
module mod_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  mod_result_bcd_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   out_bcd_q, out_bcd_d;
  logic [2:0]      nd_q, nd_d;
  logic            out_valid_q, out_valid_d;

  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shift_w;
  logic [BW-1:0]       shift_bcd;
  logic [WIDTH-1:0]    shift_bin;
  logic [2:0]          nd_calc;

  // Add-3 correction keeps every digit at or below 9 once the shift is applied.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
    end
  endgenerate

  assign shift_w   = {bcd_adj, bin_q} << 1;
  assign shift_bcd = shift_w[BW+WIDTH-1 : WIDTH];
  assign shift_bin = shift_w[WIDTH-1:0];

  always_comb begin
    nd_calc = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_bcd[4*i +: 4] != 4'd0) nd_calc = 3'(i + 1);
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    out_bcd_d   = out_bcd_q;
    nd_d        = nd_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = bus.in_data;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shift_bcd;
        bin_d = shift_bin;
        cnt_d = cnt_q - 1'b1;
        // Last iteration: publish the freshly shifted value directly.
        if (cnt_q == CW'(1)) begin
          out_bcd_d   = shift_bcd;
          nd_d        = nd_calc;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      nd_q        <= 3'd1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      nd_q        <= nd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bcd     = out_bcd_q;
  assign bus.out_ndigits = nd_q;
endmodule
